// File: rtl/uart_tx.sv
// uart_tx: 8-bit serial transmitter, LSB first, with optional even/odd parity
// and a programmable bit period.
//
// Ports
//   CLK        in   1  clock, all state updates on the rising edge
//   RST        in   1  synchronous active-low reset
//   P_DATA     in   8  byte to transmit
//   Data_Valid in   1  transmit request, honoured only while idle
//   PAR_EN     in   1  1 inserts a parity bit between data and stop
//   PAR_TYP    in   1  0 even parity, 1 odd parity
//   prescale   in   4  clock cycles per serial bit, 0 means 16
//   TX_OUT     out  1  serial line, idles high, straight from a flop
//   busy       out  1  high from frame acceptance until the stop bit ends
module uart_tx (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [3:0] prescale,
    output logic       TX_OUT,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;       // cycles spent in the current bit
    logic [2:0] idx_q, idx_d;       // data bit being sent
    logic [4:0] period_q, period_d; // latched bit period, 1..16
    logic [7:0] data_q, data_d;
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    logic       bit_done;
    logic       parity_bit;

    // Last cycle of the current bit; only meaningful outside idle, where
    // period_q is always at least 1.
    assign bit_done   = (cnt_q == (period_q - 5'd1));
    assign parity_bit = (^data_q) ^ par_typ_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        period_d  = period_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        if (state_q != StIdle) begin
            cnt_d = bit_done ? 5'd0 : (cnt_q + 5'd1);
        end

        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = 5'd0;
                idx_d  = 3'd0;
                if (Data_Valid) begin
                    // Configuration is captured here so mid-frame input
                    // changes cannot disturb the frame in flight.
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    period_d  = (prescale == 4'd0) ? 5'd16 : {1'b0, prescale};
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            StData: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 5'd0;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = 5'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            idx_q     <= 3'd0;
            period_q  <= 5'd0;
            data_q    <= 8'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            period_q  <= period_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: UART_TX

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-002 The block SHALL have the port RST, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port P_DATA, input, 8 bits: the parallel byte to transmit.
REQ-004 The block SHALL have the port Data_Valid, input, 1 bit: a transmit request, which takes effect only when busy=0.
REQ-005 The block SHALL have the port PAR_EN, input, 1 bit: 1 inserts a parity bit between data and stop.
REQ-006 The block SHALL have the port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-007 The block SHALL have the port prescale, input, 4 bits: CLK cycles per serial bit (1..15), where 0 means 16.
REQ-008 The block SHALL have the port TX_OUT, output, 1 bit: the serial line, which idles high and is registered.
REQ-009 The block SHALL have the port busy, output, 1 bit: high from frame acceptance until the stop bit completes, and registered.

Function
REQ-010 The block SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP, one-hot or binary, and SHALL NOT reach any other state.
REQ-011 In IDLE, on a rising edge with Data_Valid=1, the block SHALL latch P_DATA, PAR_EN, PAR_TYP and prescale, set TX_OUT=0 and busy=1, and enter START.
REQ-012 In IDLE with Data_Valid=0, the block SHALL hold TX_OUT=1 and busy=0.
REQ-013 The block SHALL ignore Data_Valid while busy=1: no queueing, and no corruption of the latched byte or configuration.
REQ-014 Each bit SHALL be held on TX_OUT for exactly P cycles, where P is the latched prescale (0 gives 16), using a 5-bit cycle counter that resets at each bit boundary.
REQ-015 After START completes, the block SHALL enter DATA and drive latched data bit 0 first (LSB-first) through bit 7, using a 3-bit bit index.
REQ-016 After data bit 7 completes, the block SHALL enter PARITY if latched PAR_EN=1, and otherwise enter STOP.
REQ-017 In PARITY, the block SHALL drive the XOR of the 8 latched data bits when PAR_TYP=0 (even), and its inverse when PAR_TYP=1 (odd).
REQ-018 In STOP, the block SHALL drive TX_OUT=1 for P cycles, then enter IDLE and clear busy on the same edge.
REQ-019 A new request SHALL be accepted no earlier than the first IDLE cycle, so back-to-back frames are separated by at least 1 idle-high cycle.
REQ-020 The frame length from the acceptance edge to busy falling SHALL be (10+PAR_EN)*P cycles.
REQ-021 Input changes on P_DATA, PAR_EN, PAR_TYP and prescale mid-frame SHALL NOT affect the frame in progress.
REQ-022 TX_OUT SHALL be glitch-free, driven directly from a flop.

Reset
REQ-023 With RST=0 at a rising edge, the block SHALL set the state to IDLE, TX_OUT=1 and busy=0, and clear the counters and the latched data.
REQ-024 A reset mid-frame SHALL abort the frame immediately at that edge with TX_OUT=1, and no partial frame SHALL resume after RST returns to 1.
REQ-025 If RST=0 and Data_Valid=1 occur on the same edge, reset SHALL win, and the request SHALL be dropped.

Verification
REQ-026 Scenario no-parity: P_DATA=0xA5, PAR_EN=0, prescale=8, with a 1-cycle Data_Valid pulse, SHALL give TX_OUT = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles, busy high for 80 cycles, then TX_OUT=1.
REQ-027 Scenario parity: 0xA5 with PAR_EN=1, PAR_TYP=0 SHALL give parity bit 0, and with PAR_TYP=1 SHALL give parity bit 1, with busy high for 88 cycles; 0x07 with even parity SHALL give parity bit 1.
REQ-028 Scenario ignored request: holding Data_Valid=1 with 0x3C, then changing P_DATA to 0xFF at cycle 20 of the frame, SHALL transmit 0x3C intact, with the next frame (0xFF) starting exactly 1 idle cycle after busy falls.
REQ-029 Scenario prescale extremes: prescale=1 SHALL give 1-cycle bits and a 10-cycle frame, and prescale=0 SHALL give 16-cycle bits and a 160-cycle frame, with bit values as in REQ-026.
REQ-030 Scenario reset mid-frame: RST=0 during data bit 3 SHALL give TX_OUT=1 and busy=0 after that edge, and a frame after release (0x5A) SHALL transmit cleanly.
REQ-031 Scenario reset-vs-request: RST=0 and Data_Valid=1 on the same edge SHALL give busy=0 and TX_OUT=1 with no frame started.
